// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling; define UART_RX_PARITY_EN for 8E1 with PE strobe.
module uart_rx #(
  parameter int BAUD_DIVIDER = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic [7:0] O_DATA,
  output logic       NrD,
  output logic       RiP,
  output logic       FE,
  output logic       PE
);
  localparam int CW = $clog2(BAUD_DIVIDER + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIVIDER);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIVIDER / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [1:0] flush;
  logic armed;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] sh, sh_n, data_n;
  logic nrd_n, fe_n;
  logic expired;
  assign expired = cnt == CW'(1);
  assign RiP = state != IDLE;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, pe_n;
`endif
  // A start bit only counts once the synchronizer has flushed its reset value and a real high was seen.
  always_comb begin
    state_n = state;
    cnt_n = (cnt != '0) ? cnt - 1'b1 : cnt;
    bit_n = bit_cnt;
    sh_n = sh;
    data_n = O_DATA;
    nrd_n = 1'b0;
    fe_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n = par;
    pe_n = 1'b0;
`endif
    case (state)
      IDLE: if (armed && !rx_s) begin
        state_n = START;
        cnt_n = HALF;
      end
      START: if (expired) begin
        state_n = rx_s ? IDLE : DATA;
        if (!rx_s) cnt_n = FULL;
      end
      DATA: if (expired) begin
        sh_n = {rx_s, sh[7:1]};
        bit_n = bit_cnt + 1'b1;
        cnt_n = FULL;
        if (bit_cnt == 3'd7) state_n = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (expired) begin
        par_n = rx_s;
        cnt_n = FULL;
        state_n = STOP;
      end
`endif
      STOP: if (expired) begin
        state_n = rx_s ? IDLE : WAIT_HIGH;
        nrd_n = rx_s;
        fe_n = !rx_s;
        data_n = rx_s ? sh : O_DATA;
`ifdef UART_RX_PARITY_EN
        pe_n = rx_s && (^{sh, par});
`endif
      end
      WAIT_HIGH: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      flush <= '0;
      armed <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      O_DATA <= '0;
      NrD <= 1'b0;
      FE <= 1'b0;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
      flush <= {flush[0], 1'b1};
      armed <= armed | (flush[1] & rx_s);
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      O_DATA <= data_n;
      NrD <= nrd_n;
      FE <= fe_n;
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par <= 1'b0;
      PE <= 1'b0;
    end else begin
      par <= par_n;
      PE <= pe_n;
    end
`else
  assign PE = 1'b0;
`endif
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIVIDER, default 104, meaning clk cycles per bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1, reference clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Rx, input, 1, serial line; asynchronous to clk; idle high.
REQ-005 SHALL have port O_DATA, output, 8, last received byte.
REQ-006 SHALL have port NrD, output, 1, new received data strobe.
REQ-007 SHALL have port RiP, output, 1, reception in progress.
REQ-008 SHALL have port FE, output, 1, framing error strobe.
REQ-009 SHALL have port PE, output, 1, parity error strobe.

Function
REQ-010 SHALL pass Rx through a 2-flop synchronizer, initialised high; all logic uses the synchronized value (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-012 In IDLE, SHALL move to START when rx_s is low, and load the baud counter with BAUD_DIVIDER/2 (integer division).
REQ-013 In START, at counter expiry (mid start bit): if rx_s is high, SHALL return to IDLE (glitch rejected, no strobe); if low, SHALL enter DATA with the counter reloaded to BAUD_DIVIDER.
REQ-014 In DATA, SHALL sample rx_s at each counter expiry, every BAUD_DIVIDER clocks, shifting LSB first; SHALL leave after the 8th sample via a 3-bit bit counter, wrapping 7->0.
REQ-015 After DATA, SHALL go to PARITY when the configuration macro is defined, otherwise to STOP.
REQ-016 In STOP, at expiry: rx_s high -> valid frame, return to IDLE; rx_s low -> framing error, go to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL hold until rx_s is high, then return to IDLE, so a break condition yields one FE only.
REQ-018 On a valid stop bit, SHALL update O_DATA and pulse NrD high for exactly one clk on the edge following the stop sample.
REQ-019 On a framing error, SHALL pulse FE for one clk on the same edge NrD would have pulsed; NrD SHALL stay low and O_DATA SHALL be unchanged.
REQ-020 O_DATA SHALL hold its value until the next valid frame; there is no read handshake, and an unread byte is overwritten.
REQ-021 RiP SHALL be high in every state except IDLE.
REQ-022 The baud counter SHALL be ceil(log2(BAUD_DIVIDER+1)) bits wide and count down; expiry is the cycle it reads 1.
REQ-023 A new start bit SHALL be accepted on the first clk after returning to IDLE; back-to-back frames with one stop bit SHALL be received without loss.

Reset
REQ-024 Asserting rst at any time, including mid-frame, SHALL force IDLE immediately, with synchronizer flops high, O_DATA=0, NrD=0, FE=0, PE=0, RiP=0, and all counters 0.
REQ-025 After rst deasserts, a line already low SHALL be treated as a start bit only after a high-to-low transition is seen; a partial frame SHALL produce no strobe.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is start, 8 data bits, even parity, stop; PARITY samples one bit; on mismatch, PE pulses one clk with NrD (O_DATA still updated).
REQ-027 Macro UART_RX_PARITY_EN undefined: frame is start, 8 data bits, stop (8N1); PARITY state is unreachable; PE is tied low.

Verification
REQ-028 8N1, BAUD_DIVIDER=104, send 0x55 -> one NrD pulse, O_DATA=0x55, FE=0, RiP high for the whole frame.
REQ-029 Back-to-back bytes 0xA3 then 0x0F -> two NrD pulses exactly 1040 clk apart, O_DATA 0xA3 then 0x0F.
REQ-030 Rx low pulse of 30 clk (less than 52) -> no NrD, no FE, return to IDLE.
REQ-031 Byte 0x81 with stop bit forced low, then line held low for 2000 clk -> exactly one FE pulse, no NrD, O_DATA unchanged, IDLE after line goes high.
REQ-032 Assert rst during bit 4 of 0xC6 -> all outputs zero immediately; next byte 0x3C is received correctly.
REQ-033 With UART_RX_PARITY_EN, send 0x07 with parity=0 (wrong) -> NrD and PE pulse together, O_DATA=0x07; with parity=1 -> PE=0.
